unary_add_1_4_3: RTL and testbench

Serial unary-stream adder with a count register and unary re-serialiser. In accumulate mode it adds one bit from each of two unary input streams (A, B) into a CNT_W-bit count every enabled clock. In emit mode it plays the accumulated total back as a unary pulse train on `dout`. It is a leaf block in the stochastic/unary arithmetic datapath, and it flags count overflow on `C`.

---
 rtl/unary_add_1_4_3.sv | 65 ++++++
 tb/tb_unary_add_1_4_3.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/unary_add_1_4_3.sv
// rtl/unary_add_1_4_3.sv - serial unary-stream adder with count register and unary re-serialiser
// Optional feature: define UNARY_ADD_SAT_EN to saturate the count on overflow instead of wrapping.
module unary_add_1_4_3 #(
  parameter int CNT_W = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic A,
  input  logic B,
  input  logic en,
  input  logic read_or_write,
  output logic dout,
  output logic C
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [CNT_W-1:0] count_q, count_d;
  logic             dout_q, dout_d;
  logic             c_q, c_d;
  logic [CNT_W:0]   sum;

  // One extra bit so the carry out of the count is visible as overflow.
  assign sum = {1'b0, count_q} + {{CNT_W{1'b0}}, A} + {{CNT_W{1'b0}}, B};

  always_comb begin
    count_d = count_q;
    dout_d  = 1'b0;
    c_d     = c_q;
    if (en) begin
      if (!read_or_write) begin
        if (sum[CNT_W]) begin
          c_d = 1'b1;
`ifdef UNARY_ADD_SAT_EN
          count_d = CNT_MAX;
`else
          count_d = sum[CNT_W-1:0];
`endif
        end else begin
          count_d = sum[CNT_W-1:0];
        end
      end else if (count_q != '0) begin
        dout_d  = 1'b1;
        count_d = count_q - CNT_ONE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
      dout_q  <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      count_q <= count_d;
      dout_q  <= dout_d;
      c_q     <= c_d;
    end
  end

  assign dout = dout_q;
  assign C    = c_q;

endmodule

// File: tb/tb_unary_add_1_4_3.sv
// tb/tb_unary_add_1_4_3.sv - self-checking bench for unary_add_1_4_3 (table vectors, hand sequences, random vs model)
module tb_unary_add_1_4_3;

  localparam int CW   = 4;
  localparam int MAXV = (1 << CW) - 1;
`ifdef UNARY_ADD_SAT_EN
  localparam int OVF_ONES = MAXV;
`else
  localparam int OVF_ONES = (19 * 2) % (1 << CW);
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic a = 1'b0;
  logic b = 1'b0;
  logic en = 1'b0;
  logic rw = 1'b0;
  logic dout;
  logic c;

  int checks = 0;
  int errors = 0;

  unary_add_1_4_3 #(.CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .A            (a),
    .B            (b),
    .en           (en),
    .read_or_write(rw),
    .dout         (dout),
    .C            (c)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic r;
    logic e;
    logic w;
    logic va;
    logic vb;
    logic xd;
    logic xc;
  } vec_t;

  vec_t tbl[$];

  function automatic void vec(logic r, logic e, logic w, logic va, logic vb, logic xd, logic xc);
    vec_t v;
    v = '{r, e, w, va, vb, xd, xc};
    tbl.push_back(v);
  endfunction

  task automatic apply(logic r, logic e, logic w, logic va, logic vb);
    rst_n = r; en = e; rw = w; a = va; b = vb;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string name, logic got_d, logic got_c, logic exp_d, logic exp_c);
    checks++;
    if (got_d !== exp_d || got_c !== exp_c) begin
      errors++;
      $display("FAIL %s: got dout=%b C=%b, expected dout=%b C=%b", name, got_d, got_c, exp_d, exp_c);
    end
  endtask

  // Reference model: integer count with the accumulate/emit rules applied directly.
  int m_cnt;
  int m_c;
  int m_d;

  task automatic model(logic r, logic e, logic w, logic va, logic vb);
    int s;
    if (!r) begin
      m_cnt = 0; m_c = 0; m_d = 0;
    end else if (!e) begin
      m_d = 0;
    end else if (!w) begin
      s = m_cnt + int'(va) + int'(vb);
      m_d = 0;
      if (s > MAXV) begin
        m_c = 1;
`ifdef UNARY_ADD_SAT_EN
        m_cnt = MAXV;
`else
        m_cnt = s % (MAXV + 1);
`endif
      end else begin
        m_cnt = s;
      end
    end else if (m_cnt > 0) begin
      m_d = 1;
      m_cnt = m_cnt - 1;
    end else begin
      m_d = 0;
    end
  endtask

  initial begin
    // Accumulate 5x(1+1)=10, emit 10 ones.
    vec(0, 1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 5; i++) vec(1, 1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) vec(1, 1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 2; i++) vec(1, 1, 1, 0, 0, 0, 0);
    // Overflow at the 8th edge, then emit the wrapped/saturated total.
    vec(0, 1, 0, 1, 1, 0, 0);
    for (int k = 1; k <= 19; k++) vec(1, 1, 0, 1, 1, 0, (k >= 8) ? 1'b1 : 1'b0);
    for (int i = 0; i < OVF_ONES; i++) vec(1, 1, 1, 0, 0, 1, 1);
    for (int i = 0; i < 2; i++) vec(1, 1, 1, 0, 0, 0, 1);
    // Reset clears a set C.
    vec(0, 1, 1, 1, 1, 0, 0);
    // Mixed streams -> 5.
    for (int i = 0; i < 3; i++) vec(1, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 2; i++) vec(1, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 2; i++) vec(1, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 5; i++) vec(1, 1, 1, 1, 1, 1, 0);
    vec(1, 1, 1, 1, 1, 0, 0);
    // en=0 holds count during accumulate.
    vec(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) vec(1, 1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) vec(1, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) vec(1, 1, 1, 0, 0, 1, 0);
    vec(1, 1, 1, 0, 0, 0, 0);
    // Mode toggling: 4, emit 2, +3 -> 5.
    vec(0, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) vec(1, 1, 0, 1, 1, 0, 0);
    for (int i = 0; i < 2; i++) vec(1, 1, 1, 0, 0, 1, 0);
    for (int i = 0; i < 3; i++) vec(1, 1, 0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) vec(1, 1, 1, 0, 0, 1, 0);
    vec(1, 1, 1, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    #1;
    foreach (tbl[i]) begin
      apply(tbl[i].r, tbl[i].e, tbl[i].w, tbl[i].va, tbl[i].vb);
      chk($sformatf("vec%0d", i), dout, c, tbl[i].xd, tbl[i].xc);
    end

    // Pause emit with en=0 after 2 of 6 ones, then resume.
    apply(0, 1, 0, 0, 0);
    chk("pause_rst", dout, c, 0, 0);
    for (int i = 0; i < 3; i++) apply(1, 1, 0, 1, 1);
    for (int i = 0; i < 2; i++) begin
      apply(1, 1, 1, 0, 0);
      chk("pause_pre", dout, c, 1, 0);
    end
    for (int i = 0; i < 3; i++) begin
      apply(1, 0, 1, 0, 0);
      chk("pause_hold", dout, c, 0, 0);
    end
    for (int i = 0; i < 4; i++) begin
      apply(1, 1, 1, 0, 0);
      chk("pause_post", dout, c, 1, 0);
    end
    apply(1, 1, 1, 0, 0);
    chk("pause_done", dout, c, 0, 0);

    // Reset mid-emit after 3 of 10 ones.
    apply(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) apply(1, 1, 0, 1, 1);
    for (int i = 0; i < 3; i++) begin
      apply(1, 1, 1, 0, 0);
      chk("midrst_pre", dout, c, 1, 0);
    end
    apply(0, 1, 1, 0, 0);
    chk("midrst_edge", dout, c, 0, 0);
    for (int i = 0; i < 3; i++) begin
      apply(1, 1, 1, 0, 0);
      chk("midrst_after", dout, c, 0, 0);
    end

    // Random stimulus against the model.
    apply(0, 1, 0, 0, 0);
    model(0, 1, 0, 0, 0);
    chk("rand_rst", dout, c, m_d[0], m_c[0]);
    begin
      logic r, e, w, va, vb;
      w = 1'b0;
      for (int i = 0; i < 600; i++) begin
        r  = ($urandom_range(0, 99) >= 2);
        e  = ($urandom_range(0, 99) >= 20);
        if ($urandom_range(0, 9) == 0) w = ~w;
        va = 1'($urandom);
        vb = 1'($urandom);
        apply(r, e, w, va, vb);
        model(r, e, w, va, vb);
        chk($sformatf("rand%0d", i), dout, c, m_d[0], m_c[0]);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
